// File: rtl/block_drop_ctrl.sv
// Falling-block controller: spawns a block, drops it one row per step period,
// and drives erase/draw plot handshakes with the drawing datapath until it lands.
module block_drop_ctrl #(
  parameter logic [19:0] TICK_MAX        = 20'd833332,
  parameter logic [3:0]  FRAMES_PER_STEP = 4'd15,
  parameter logic [7:0]  X_INIT          = 8'd76,
  parameter logic [6:0]  Y_MAX           = 7'd116
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       enable,
  input  logic       blocked,
  input  logic       plot_done,
  output logic       plot_req,
  output logic       erase,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       landed,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_WAIT, S_CHECK, S_ERASE, S_MOVE, S_DRAW, S_LAND
  } state_t;

  state_t      state;
  logic [19:0] tick_cnt;
  logic [3:0]  frame_cnt;
  logic        handshake;

  // A plot completes only while a request is actually outstanding.
  assign handshake = plot_req & plot_done;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_IDLE;
      plot_req  <= 1'b0;
      erase     <= 1'b0;
      landed    <= 1'b0;
      busy      <= 1'b0;
      x         <= 8'd0;
      y         <= 7'd0;
      tick_cnt  <= TICK_MAX;
      frame_cnt <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SPAWN;
            x        <= X_INIT;
            y        <= 7'd0;
            plot_req <= 1'b1;
            erase    <= 1'b0;
            busy     <= 1'b1;
          end
        end

        S_SPAWN, S_DRAW: begin
          if (handshake) begin
            state     <= S_WAIT;
            plot_req  <= 1'b0;
            tick_cnt  <= TICK_MAX;
            frame_cnt <= 4'd0;
          end
        end

        // Step period is (TICK_MAX+1)*FRAMES_PER_STEP enabled cycles.
        S_WAIT: begin
          if (enable) begin
            if (tick_cnt == 20'd0) begin
              tick_cnt <= TICK_MAX;
              if (frame_cnt == FRAMES_PER_STEP - 4'd1) begin
                frame_cnt <= 4'd0;
                state     <= S_CHECK;
              end else begin
                frame_cnt <= frame_cnt + 4'd1;
              end
            end else begin
              tick_cnt <= tick_cnt - 20'd1;
            end
          end
        end

        S_CHECK: begin
          if (blocked || (y == Y_MAX)) begin
            state  <= S_LAND;
            landed <= 1'b1;
          end else begin
            state    <= S_ERASE;
            plot_req <= 1'b1;
            erase    <= 1'b1;
          end
        end

        S_ERASE: begin
          if (handshake) begin
            state    <= S_MOVE;
            plot_req <= 1'b0;
            erase    <= 1'b0;
          end
        end

        S_MOVE: begin
          if (y < Y_MAX) y <= y + 7'd1;
          state    <= S_DRAW;
          plot_req <= 1'b1;
          erase    <= 1'b0;
        end

        S_LAND: begin
          state  <= S_IDLE;
          landed <= 1'b0;
          busy   <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          plot_req <= 1'b0;
          erase    <= 1'b0;
          landed   <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_drop_ctrl.sv
// Directed bench for block_drop_ctrl with small parameters so a full drop
// takes only a few dozen cycles; each step period is 8 enabled WAIT cycles.
module tb_block_drop_ctrl;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       enable = 1'b1;
  logic       blocked = 1'b0;
  logic       plot_done = 1'b0;
  logic       plot_req;
  logic       erase;
  logic [7:0] x;
  logic [6:0] y;
  logic       landed;
  logic       busy;

  int total = 0;
  int bad = 0;

  block_drop_ctrl #(
    .TICK_MAX(20'd3), .FRAMES_PER_STEP(4'd2), .X_INIT(8'd10), .Y_MAX(7'd3)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .enable(enable),
    .blocked(blocked), .plot_done(plot_done), .plot_req(plot_req),
    .erase(erase), .x(x), .y(y), .landed(landed), .busy(busy)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are observed on the falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic handshake();
    plot_done = 1'b1;
    step();
    plot_done = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!plot_req && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic spawn_and_start_wait();
    start = 1'b1;
    step();
    start = 1'b0;
    handshake();
  endtask

  // Finishes the current drop by forcing a collision, serving any plots.
  task automatic run_to_land(output int n);
    blocked = 1'b1;
    n = 0;
    while (!landed && n < 200) begin
      plot_done = plot_req;
      step();
      n++;
    end
    plot_done = 1'b0;
    blocked = 1'b0;
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    total++;
    if (plot_req !== 1'b0 || erase !== 1'b0 || landed !== 1'b0 || busy !== 1'b0 ||
        x !== 8'd0 || y !== 7'd0) begin
      bad++;
      $display("[TB] FAIL reset: req=%b erase=%b landed=%b busy=%b x=%0d y=%0d, want all 0",
               plot_req, erase, landed, busy, x, y);
    end
  endtask

  task automatic test_full_drop();
    int n;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (plot_req !== 1'b1 || erase !== 1'b0 || x !== 8'd10 || y !== 7'd0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL spawn: req=%b erase=%b x=%0d y=%0d busy=%b, want 1 0 10 0 1",
               plot_req, erase, x, y, busy);
    end
    handshake();
    total++;
    if (plot_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL spawn_release: req=%b, want 0", plot_req);
    end
    for (int r = 0; r < 3; r++) begin
      wait_req(n);
      total++;
      if (n != 9) begin
        bad++;
        $display("[TB] FAIL step_period row %0d: %0d cycles, want 9", r, n);
      end
      total++;
      if (erase !== 1'b1 || y !== 7'(r) || x !== 8'd10) begin
        bad++;
        $display("[TB] FAIL erase_plot row %0d: erase=%b x=%0d y=%0d, want 1 10 %0d",
                 r, erase, x, y, r);
      end
      handshake();
      wait_req(n);
      total++;
      if (n != 1 || erase !== 1'b0 || y !== 7'(r + 1) || x !== 8'd10) begin
        bad++;
        $display("[TB] FAIL draw_plot row %0d: gap=%0d erase=%b x=%0d y=%0d, want 1 0 10 %0d",
                 r, n, erase, x, y, r + 1);
      end
      handshake();
    end
    n = 0;
    while (!landed && n < 50) begin
      step();
      n++;
    end
    total++;
    if (n != 9 || y !== 7'd3 || x !== 8'd10 || busy !== 1'b1 || plot_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL land_bottom: cycles=%0d y=%0d x=%0d busy=%b req=%b, want 9 3 10 1 0",
               n, y, x, busy, plot_req);
    end
    step();
    total++;
    if (landed !== 1'b0 || busy !== 1'b0 || y !== 7'd3 || x !== 8'd10) begin
      bad++;
      $display("[TB] FAIL after_land: landed=%b busy=%b x=%0d y=%0d, want 0 0 10 3",
               landed, busy, x, y);
    end
  endtask

  task automatic test_blocked();
    int n;
    bit saw_req;
    spawn_and_start_wait();
    blocked = 1'b1;
    n = 0;
    saw_req = 1'b0;
    while (!landed && n < 50) begin
      step();
      n++;
      if (plot_req) saw_req = 1'b1;
    end
    blocked = 1'b0;
    total++;
    if (n != 9 || saw_req || y !== 7'd0) begin
      bad++;
      $display("[TB] FAIL blocked_land: cycles=%0d plot_seen=%b y=%0d, want 9 0 0", n, saw_req, y);
    end
    step();
    total++;
    if (landed !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL blocked_pulse: landed=%b busy=%b, want 0 0", landed, busy);
    end
  endtask

  task automatic test_pause();
    int n;
    spawn_and_start_wait();
    repeat (3) step();
    enable = 1'b0;
    repeat (5) step();
    enable = 1'b1;
    wait_req(n);
    total++;
    if (n != 6 || erase !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pause_delay: remaining=%0d erase=%b, want 6 1", n, erase);
    end
    run_to_land(n);
    total++;
    if (n >= 200 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL pause_finish: cycles=%0d busy=%b, want <200 0", n, busy);
    end
  endtask

  task automatic test_stall();
    int n;
    bit ok;
    spawn_and_start_wait();
    ok = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      plot_done = (k == 2 || k == 5);
      step();
      if (plot_req !== 1'b0) ok = 1'b0;
    end
    plot_done = 1'b0;
    step();
    total++;
    if (!ok || plot_req !== 1'b1 || erase !== 1'b1 || y !== 7'd0) begin
      bad++;
      $display("[TB] FAIL stray_done: quiet=%b req=%b erase=%b y=%0d, want 1 1 1 0",
               ok, plot_req, erase, y);
    end
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (plot_req !== 1'b1 || erase !== 1'b1 || y !== 7'd0 || x !== 8'd10) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL erase_stall: req=%b erase=%b x=%0d y=%0d, want held 1 1 10 0",
               plot_req, erase, x, y);
    end
    handshake();
    total++;
    if (plot_req !== 1'b0 || erase !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_release: req=%b erase=%b, want 0 0", plot_req, erase);
    end
    run_to_land(n);
  endtask

  task automatic test_reset_mid();
    int n;
    spawn_and_start_wait();
    wait_req(n);
    handshake();
    wait_req(n);
    resetn = 1'b0;
    plot_done = 1'b1;
    step();
    total++;
    if (plot_req !== 1'b0 || erase !== 1'b0 || landed !== 1'b0 || busy !== 1'b0 ||
        x !== 8'd0 || y !== 7'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid: req=%b erase=%b landed=%b busy=%b x=%0d y=%0d, want all 0",
               plot_req, erase, landed, busy, x, y);
    end
    resetn = 1'b1;
    step();
    plot_done = 1'b0;
    total++;
    if (plot_req !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL late_done: req=%b busy=%b, want 0 0", plot_req, busy);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (plot_req !== 1'b1 || erase !== 1'b0 || x !== 8'd10 || y !== 7'd0) begin
      bad++;
      $display("[TB] FAIL respawn: req=%b erase=%b x=%0d y=%0d, want 1 0 10 0",
               plot_req, erase, x, y);
    end
    run_to_land(n);
  endtask

  task automatic test_back_to_back();
    int n;
    spawn_and_start_wait();
    repeat (2) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_req(n);
    total++;
    if (n != 6 || erase !== 1'b1) begin
      bad++;
      $display("[TB] FAIL start_in_wait: remaining=%0d erase=%b, want 6 1", n, erase);
    end
    handshake();
    wait_req(n);
    handshake();
    blocked = 1'b1;
    n = 0;
    while (!landed && n < 50) begin
      step();
      n++;
    end
    blocked = 1'b0;
    start = 1'b1;
    step();
    total++;
    if (landed !== 1'b0 || busy !== 1'b0 || plot_req !== 1'b0 || y !== 7'd1) begin
      bad++;
      $display("[TB] FAIL start_in_land: landed=%b busy=%b req=%b y=%0d, want 0 0 0 1",
               landed, busy, plot_req, y);
    end
    step();
    start = 1'b0;
    total++;
    if (plot_req !== 1'b1 || busy !== 1'b1 || x !== 8'd10 || y !== 7'd0) begin
      bad++;
      $display("[TB] FAIL start_after_land: req=%b busy=%b x=%0d y=%0d, want 1 1 10 0",
               plot_req, busy, x, y);
    end
    run_to_land(n);
  endtask

  initial begin
    step();
    test_reset();
    test_full_drop();
    test_blocked();
    test_pause();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
